// File: rtl/dbe_pkg.sv
// Shared definitions for the dbe decoder back-end stages: plain-data field
// layout, marker codes and the packer state encoding.
package dbe_pkg;

   localparam int PD_SYM_W         = 8;
   localparam int PD_MARK_W        = 4;
   localparam int PD_W             = 1 + PD_SYM_W + PD_MARK_W;
   localparam int PD_MARK_LSB      = 0;
   localparam int PD_SYM_LSB       = PD_MARK_LSB + PD_MARK_W;
   localparam int PD_IS_MARKER_BIT = PD_SYM_LSB + PD_SYM_W;

   localparam int NUM_BYTES_DEFAULT = 4;

   localparam logic [PD_MARK_W-1:0] MARK_NONE    = 4'd0;
   localparam logic [PD_MARK_W-1:0] MARK_END     = 4'd1;
   localparam logic [PD_MARK_W-1:0] MARK_RESET   = 4'd2;
   localparam logic [PD_MARK_W-1:0] MARK_ERR_MIN = 4'd3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } pack_state_e;

   typedef enum logic [1:0] {
      MK_NONE,
      MK_END,
      MK_RESET,
      MK_ERROR
   } mark_kind_e;

   // Every code at or above MARK_ERR_MIN is an error, whatever its value.
   function automatic mark_kind_e decode_mark(input logic [PD_MARK_W-1:0] mark);
      mark_kind_e kind;
      if (mark >= MARK_ERR_MIN)
         kind = MK_ERROR;
      else if (mark == MARK_RESET)
         kind = MK_RESET;
      else if (mark == MARK_END)
         kind = MK_END;
      else
         kind = MK_NONE;
      return kind;
   endfunction

endpackage

// File: rtl/dbe_out_reg.sv
// Single-entry valid/ready holding register. The producer may load whenever
// space is high, which includes the cycle the current entry is being popped.
module dbe_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         vld,
   input  logic         rdy,
   output logic         space
);

   assign space = !vld || rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= 1'b0;
         q   <= '0;
      end else begin
         if (load) begin
            vld <= 1'b1;
            q   <= d;
         end else if (rdy) begin
            vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dbe_plain_data_packer.sv
// Packs the LZ4 decoder's plain-data symbols into NUM_BYTES-wide words and
// turns END / RESET / ERROR markers into word boundaries and frame flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | packing symbols; END closes a frame, ERROR closes it with err
//   ST_DRAIN | after an error: drop everything until a RESET marker
module dbe_plain_data_packer
   import dbe_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DEFAULT,
   parameter int SYM_W     = PD_SYM_W,
   parameter int MARK_W    = PD_MARK_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SYM_W+MARK_W:0]      i_data_data,
   input  logic                       i_data_vld,
   output logic                       i_data_rdy,
   output logic [NUM_BYTES*SYM_W-1:0] o_word_data,
   output logic [NUM_BYTES-1:0]       o_word_keep,
   output logic                       o_word_last,
   output logic                       o_word_err,
   output logic                       o_word_vld,
   input  logic                       o_word_rdy
);

   localparam int FILL_W = $clog2(NUM_BYTES) + 1;
   localparam int WORD_W = NUM_BYTES * SYM_W;
   localparam int OUT_W  = WORD_W + NUM_BYTES + 2;

   logic              is_marker;
   logic [SYM_W-1:0]  sym;
   logic [MARK_W-1:0] mark;
   mark_kind_e        kind;

   pack_state_e       state, state_nxt;
   logic [WORD_W-1:0] acc, acc_nxt, acc_wr;
   logic [FILL_W-1:0] fill, fill_nxt;
   logic [NUM_BYTES-1:0] part_keep;

   logic                 accept;
   logic                 out_space;
   logic                 load;
   logic [WORD_W-1:0]    ld_data;
   logic [NUM_BYTES-1:0] ld_keep;
   logic                 ld_last;
   logic                 ld_err;
   logic [OUT_W-1:0]     out_q;

   assign is_marker = i_data_data[SYM_W+MARK_W];
   assign sym       = i_data_data[MARK_W +: SYM_W];
   assign mark      = i_data_data[MARK_W-1:0];
   assign kind      = decode_mark(mark);

   // Ready is gated by reset so nothing is accepted while rst is low.
   assign i_data_rdy = rst && out_space;
   assign accept     = i_data_vld && i_data_rdy;

   always_comb begin
      acc_wr    = acc;
      part_keep = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (fill == FILL_W'(i))
            acc_wr[i*SYM_W +: SYM_W] = sym;
         part_keep[i] = (FILL_W'(i) < fill);
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      fill_nxt  = fill;
      load      = 1'b0;
      ld_data   = acc;
      ld_keep   = part_keep;
      ld_last   = 1'b0;
      ld_err    = 1'b0;

      if (accept) begin
         case (state)
            ST_RUN: begin
               if (!is_marker) begin
                  if (fill == FILL_W'(NUM_BYTES - 1)) begin
                     load     = 1'b1;
                     ld_data  = acc_wr;
                     ld_keep  = '1;
                     acc_nxt  = '0;
                     fill_nxt = '0;
                  end else begin
                     acc_nxt  = acc_wr;
                     fill_nxt = fill + FILL_W'(1);
                  end
               end else begin
                  case (kind)
                     MK_END: begin
                        load     = 1'b1;
                        ld_last  = 1'b1;
                        acc_nxt  = '0;
                        fill_nxt = '0;
                     end
                     MK_RESET: begin
                        acc_nxt  = '0;
                        fill_nxt = '0;
                     end
                     MK_ERROR: begin
                        load      = 1'b1;
                        ld_last   = 1'b1;
                        ld_err    = 1'b1;
                        acc_nxt   = '0;
                        fill_nxt  = '0;
                        state_nxt = ST_DRAIN;
                     end
                     default: ;
                  endcase
               end
            end
            ST_DRAIN: begin
               if (is_marker && kind == MK_RESET) begin
                  acc_nxt   = '0;
                  fill_nxt  = '0;
                  state_nxt = ST_RUN;
               end
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         acc   <= '0;
         fill  <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         fill  <= fill_nxt;
      end
   end

   dbe_out_reg #(
      .W (OUT_W)
   ) u_out_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .d     ({ld_err, ld_last, ld_keep, ld_data}),
      .q     (out_q),
      .vld   (o_word_vld),
      .rdy   (o_word_rdy),
      .space (out_space)
   );

   assign {o_word_err, o_word_last, o_word_keep, o_word_data} = out_q;

endmodule

// File: tb/tb_dbe_plain_data_packer.sv
// Self-checking bench for dbe_plain_data_packer: expected words are queued as
// stimulus is driven and compared as the DUT hands each word over.
module tb_dbe_plain_data_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        err;
   } word_t;

   logic        clk;
   logic        rst;
   logic [12:0] i_data_data;
   logic        i_data_vld;
   logic        i_data_rdy;
   logic [31:0] o_word_data;
   logic [3:0]  o_word_keep;
   logic        o_word_last;
   logic        o_word_err;
   logic        o_word_vld;
   logic        o_word_rdy;

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   word_t exp_q[$];
   int    pop_cyc[$];

   dbe_plain_data_packer #(
      .NUM_BYTES (4),
      .SYM_W     (8),
      .MARK_W    (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_data_data (i_data_data),
      .i_data_vld  (i_data_vld),
      .i_data_rdy  (i_data_rdy),
      .o_word_data (o_word_data),
      .o_word_keep (o_word_keep),
      .o_word_last (o_word_last),
      .o_word_err  (o_word_err),
      .o_word_vld  (o_word_vld),
      .o_word_rdy  (o_word_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // A transfer happens on the next rising edge whenever vld && rdy here.
   always @(negedge clk) begin
      word_t e;
      if (rst && o_word_vld && o_word_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got data=%h keep=%h last=%b err=%b, required no word",
                     o_word_data, o_word_keep, o_word_last, o_word_err);
         end else begin
            e = exp_q.pop_front();
            if ({o_word_data, o_word_keep, o_word_last, o_word_err} !== e) begin
               errors++;
               $display("FAIL word: got data=%h keep=%h last=%b err=%b, required data=%h keep=%h last=%b err=%b",
                        o_word_data, o_word_keep, o_word_last, o_word_err,
                        e.data, e.keep, e.last, e.err);
            end
         end
         pop_cyc.push_back(cyc);
      end
   end

   function automatic logic [12:0] sym(input logic [7:0] s);
      return {1'b0, s, 4'h0};
   endfunction

   function automatic logic [12:0] mk(input logic [3:0] m);
      return {1'b1, 8'h00, m};
   endfunction

   function automatic word_t w(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic e);
      word_t r;
      r.data = d; r.keep = k; r.last = l; r.err = e;
      return r;
   endfunction

   task automatic send(input logic [12:0] d, output int stalls);
      bit ok;
      ok = 1'b0;
      stalls = 0;
      i_data_data = d;
      i_data_vld  = 1'b1;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = i_data_rdy;
         if (!ok) stalls++;
         @(posedge clk);
      end
      #1 i_data_vld = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: input %h not accepted in 200 cycles, required acceptance", d);
      end
   endtask

   task automatic send_n(input logic [12:0] d);
      int st;
      send(d, st);
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (o_word_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", o_word_vld); end
      checks++; if (o_word_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", o_word_data); end
      checks++; if (o_word_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h required 0", o_word_keep); end
      checks++; if (o_word_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", o_word_last); end
      checks++; if (o_word_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", o_word_err); end
      checks++; if (i_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b required 0", i_data_rdy); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_word();
      o_word_rdy = 1'b1;
      exp_q.push_back(w(32'h44332211, 4'hF, 1'b0, 1'b0));
      exp_q.push_back(w(32'h00000000, 4'h0, 1'b1, 1'b0));
      send_n(sym(8'h11)); send_n(sym(8'h22)); send_n(sym(8'h33)); send_n(sym(8'h44));
      send_n(mk(4'd1));
      wait_drain("full_word");
   endtask

   task automatic test_partial();
      pop_cyc.delete();
      exp_q.push_back(w(32'h0000BBAA, 4'h3, 1'b1, 1'b0));
      send_n(sym(8'hAA)); send_n(sym(8'hBB)); send_n(mk(4'd1));
      wait_drain("partial");
      checks++;
      if (pop_cyc.size() != 1) begin
         errors++;
         $display("FAIL partial_count: got %0d words required 1", pop_cyc.size());
      end
   endtask

   task automatic test_error_drain();
      exp_q.push_back(w(32'h00000201, 4'h3, 1'b1, 1'b1));
      exp_q.push_back(w(32'h00000005, 4'h1, 1'b1, 1'b0));
      send_n(sym(8'h01)); send_n(sym(8'h02)); send_n(mk(4'd5));
      send_n(sym(8'h03)); send_n(sym(8'h04)); send_n(mk(4'd9));
      send_n(mk(4'd2));
      send_n(sym(8'h05)); send_n(mk(4'd1));
      wait_drain("error_drain");
   endtask

   task automatic test_backpressure();
      o_word_rdy = 1'b0;
      exp_q.push_back(w(32'h03020100, 4'hF, 1'b0, 1'b0));
      exp_q.push_back(w(32'h07060504, 4'hF, 1'b0, 1'b0));
      fork
         begin
            for (int i = 0; i < 8; i++) send_n(sym(8'(i)));
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
               @(negedge clk);
               seen = o_word_vld;
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL bp_first_vld: got vld=0 required 1"); end
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (!o_word_vld || o_word_data !== 32'h03020100) begin
                  errors++;
                  $display("FAIL bp_hold: got vld=%b data=%h required vld=1 data=03020100", o_word_vld, o_word_data);
               end
               checks++;
               if (i_data_rdy !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_in_rdy: got %b required 0", i_data_rdy);
               end
            end
            @(posedge clk); #1 o_word_rdy = 1'b1;
         end
      join
      wait_drain("backpressure");
   endtask

   task automatic test_midframe_reset();
      o_word_rdy = 1'b1;
      send_n(sym(8'h61)); send_n(sym(8'h62)); send_n(sym(8'h63));
      #2 rst = 1'b0;
      #1;
      checks++; if (o_word_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %b required 0", o_word_vld); end
      checks++; if (i_data_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_in_rdy: got %b required 0", i_data_rdy); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(w(32'h00000000, 4'h0, 1'b1, 1'b0));
      send_n(mk(4'd1));
      wait_drain("mid_rst_end");

      pop_cyc.delete();
      o_word_rdy = 1'b0;
      send_n(sym(8'h71)); send_n(sym(8'h72)); send_n(sym(8'h73)); send_n(sym(8'h74));
      checks++; if (o_word_vld !== 1'b1) begin errors++; $display("FAIL pend_vld: got %b required 1", o_word_vld); end
      #2 rst = 1'b0;
      #1;
      checks++; if (o_word_vld !== 1'b0) begin errors++; $display("FAIL pend_rst_vld: got %b required 0", o_word_vld); end
      checks++; if (o_word_keep !== 4'h0) begin errors++; $display("FAIL pend_rst_keep: got %h required 0", o_word_keep); end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1 o_word_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (pop_cyc.size() != 0) begin errors++; $display("FAIL pend_lost: got %0d words required 0", pop_cyc.size()); end
   endtask

   task automatic test_stream();
      int total, st, bad;
      logic [7:0] v[64];
      total = 0; bad = 0;
      pop_cyc.delete();
      o_word_rdy = 1'b1;
      for (int i = 0; i < 64; i++) v[i] = 8'((i * 37 + 5) & 255);
      for (int k = 0; k < 16; k++)
         exp_q.push_back(w({v[4*k+3], v[4*k+2], v[4*k+1], v[4*k]}, 4'hF, 1'b0, 1'b0));
      for (int i = 0; i < 64; i++) begin
         send(sym(v[i]), st);
         total += st;
      end
      wait_drain("stream");
      checks++; if (total != 0) begin errors++; $display("FAIL stream_stalls: got %0d required 0", total); end
      checks++;
      if (pop_cyc.size() != 16) begin
         errors++; $display("FAIL stream_count: got %0d required 16", pop_cyc.size());
      end else begin
         for (int k = 1; k < 16; k++) if (pop_cyc[k] - pop_cyc[k-1] != 4) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL stream_spacing: got %0d irregular gaps required 0", bad); end
      end
   endtask

   task automatic test_back_to_back();
      int total, st, bad;
      total = 0; bad = 0;
      pop_cyc.delete();
      o_word_rdy = 1'b1;
      send_n(sym(8'hC1));
      exp_q.push_back(w(32'h000000C1, 4'h1, 1'b1, 1'b0));
      for (int k = 0; k < 4; k++) exp_q.push_back(w(32'h0, 4'h0, 1'b1, 1'b0));
      for (int k = 0; k < 5; k++) begin
         send(mk(4'd1), st);
         total += st;
      end
      wait_drain("b2b");
      checks++; if (total != 0) begin errors++; $display("FAIL b2b_stalls: got %0d required 0", total); end
      checks++;
      if (pop_cyc.size() != 5) begin
         errors++; $display("FAIL b2b_count: got %0d required 5", pop_cyc.size());
      end else begin
         for (int k = 1; k < 5; k++) if (pop_cyc[k] - pop_cyc[k-1] != 1) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL b2b_spacing: got %0d bubbles required 0", bad); end
      end
   endtask

   initial begin
      rst         = 1'b0;
      i_data_vld  = 1'b0;
      i_data_data = '0;
      o_word_rdy  = 1'b1;
      test_reset();
      test_full_word();
      test_partial();
      test_error_drain();
      test_backpressure();
      test_midframe_reset();
      test_stream();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
